// File: rtl/kissp_core.sv
// kissp_core: a small multi-cycle load/store core with FETCH/EXEC/MEM states,
// a 32-entry register file and branches based on r31.
module kissp_core #(
  parameter int DW      = 32,
  parameter int AW      = 12,
  parameter int BR_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          insn_req,
  output logic [AW-1:0] insn_addr,
  input  logic          insn_ack,
  input  logic [31:0]   insn,
  output logic          data_req,
  output logic          data_w,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_out,
  input  logic [DW-1:0] data_in,
  input  logic          data_ack,
  output logic [DW-1:0] reg_31,
  output logic [31:0]   instret
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, npc_q, npc_d;
  logic [24:0]   ir_q, ir_d;
  logic [31:0]   instret_q, instret_d;
  logic          dreq_q, dreq_d, dw_q, dw_d;
  logic [AW-1:0] daddr_q, daddr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] rf_q [32];

  logic          wen;
  logic [4:0]    waddr;
  logic [DW-1:0] wdata;

  logic unused_insn;
  assign unused_insn = ^insn[31:25];

  logic [4:0] src1, src2, dst, imm;
  logic       m_w, r_w, op, r_src, b;
  assign src1  = ir_q[4:0];
  assign src2  = ir_q[9:5];
  assign dst   = ir_q[14:10];
  assign imm   = ir_q[19:15];
  assign m_w   = ir_q[20];
  assign r_w   = ir_q[21];
  assign op    = ir_q[22];
  assign r_src = ir_q[23];
  assign b     = ir_q[24];

  logic [DW-1:0] rs1, rs2, rdst, r31, imm_x, alu;
  logic [AW-1:0] br_tgt;
  assign rs1   = (src1 == 5'd0) ? '0 : rf_q[src1];
  assign rs2   = (src2 == 5'd0) ? '0 : rf_q[src2];
  assign rdst  = (dst  == 5'd0) ? '0 : rf_q[dst];
  assign r31   = rf_q[31];
  assign imm_x = {{(DW-5){imm[4]}}, imm};
  assign alu   = op ? (rs1 + rs2 + imm_x) : (rs1 - rs2 + imm_x);

  // r31 is sampled in EXEC, so a load into r31 cannot disturb its own branch.
  always_comb begin
    br_tgt = pc_q + AW'(1);
    if (b) br_tgt = (BR_MODE != 0) ? r31[AW-1:0] : (pc_q + r31[AW-1:0]);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    dreq_d    = dreq_q;
    dw_d      = dw_q;
    daddr_d   = daddr_q;
    dout_d    = dout_q;
    wen       = 1'b0;
    waddr     = dst;
    wdata     = alu;
    case (state_q)
      FETCH: if (insn_ack) begin
        ir_d    = insn[24:0];
        state_d = EXEC;
      end
      EXEC: if (m_w || r_src) begin
        state_d = MEM;
        dreq_d  = 1'b1;
        dw_d    = m_w;
        daddr_d = alu[AW-1:0];
        dout_d  = rdst;
        npc_d   = br_tgt;
      end else begin
        wen       = r_w;
        pc_d      = br_tgt;
        instret_d = instret_q + 32'd1;
        state_d   = FETCH;
      end
      MEM: if (data_ack) begin
        wen       = !m_w && r_w;
        wdata     = data_in;
        pc_d      = npc_q;
        instret_d = instret_q + 32'd1;
        dreq_d    = 1'b0;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      npc_q     <= '0;
      ir_q      <= '0;
      instret_q <= '0;
      dreq_q    <= 1'b0;
      dw_q      <= 1'b0;
      daddr_q   <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      dreq_q    <= dreq_d;
      dw_q      <= dw_d;
      daddr_q   <= daddr_d;
      dout_q    <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wen && waddr != 5'd0) begin
      rf_q[waddr] <= wdata;
    end
  end

  assign insn_req  = (state_q == FETCH);
  assign insn_addr = pc_q;
  assign data_req  = dreq_q;
  assign data_w    = dw_q;
  assign data_addr = daddr_q;
  assign data_out  = dout_q;
  assign reg_31    = r31;
  assign instret   = instret_q;
endmodule

// File: tb/tb_kissp_core.sv
// Bench for kissp_core: table-driven ALU vectors observed through stores into a
// scoreboard, plus hand sequences for reset, wait states, branches and reset-in-MEM.
module tb_kissp_core;
  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          insn_ack = 1'b0;
  logic [31:0]   insn = '0;
  logic [DW-1:0] data_in = '0;
  logic          data_ack = 1'b0;

  logic          insn_req, data_req, data_w;
  logic [AW-1:0] insn_addr, data_addr;
  logic [DW-1:0] data_out, reg_31;
  logic [31:0]   instret;

  logic          a_insn_req, a_data_req, a_data_w;
  logic [AW-1:0] a_insn_addr, a_data_addr;
  logic [DW-1:0] a_data_out, a_reg_31;
  logic [31:0]   a_instret;

  always #5 clk = ~clk;

  kissp_core #(.DW(DW), .AW(AW), .BR_MODE(0)) u_dut (
    .clk(clk), .rst(rst), .insn_req(insn_req), .insn_addr(insn_addr),
    .insn_ack(insn_ack), .insn(insn), .data_req(data_req), .data_w(data_w),
    .data_addr(data_addr), .data_out(data_out), .data_in(data_in),
    .data_ack(data_ack), .reg_31(reg_31), .instret(instret));

  kissp_core #(.DW(DW), .AW(AW), .BR_MODE(1)) u_abs (
    .clk(clk), .rst(rst), .insn_req(a_insn_req), .insn_addr(a_insn_addr),
    .insn_ack(insn_ack), .insn(insn), .data_req(a_data_req), .data_w(a_data_w),
    .data_addr(a_data_addr), .data_out(a_data_out), .data_in(data_in),
    .data_ack(data_ack), .reg_31(a_reg_31), .instret(a_instret));

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } st_t;
  typedef struct packed {
    logic [DW-1:0] a; logic [DW-1:0] b; logic [4:0] imm; logic op; logic [DW-1:0] exp;
  } vec_t;

  st_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] s1, input logic [4:0] s2,
      input logic [4:0] d, input logic [4:0] im, input logic mw, input logic rw,
      input logic op, input logic rs, input logic b);
    enc = {7'h55, b, rs, op, rw, mw, im, d, s2, s1};
  endfunction

  function automatic logic [31:0] ld(input logic [4:0] d);
    ld = enc(5'd0, 5'd0, d, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic logic [31:0] st(input logic [4:0] d, input logic [4:0] a);
    st = enc(5'd0, 5'd0, d, a, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  // Completed stores are popped and compared against the expected queue.
  always @(negedge clk) begin
    st_t e;
    if (!rst && data_req && data_w && data_ack) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_store: got addr 0x%0h data 0x%0h expected none", data_addr, data_out);
      end else begin
        e = sb_q.pop_front();
        chk("sb_addr", 64'(data_addr), 64'(e.addr));
        chk("sb_data", 64'(data_out), 64'(e.data));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; insn_ack = 1'b0; data_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(input logic [31:0] w, input int wait_n, input logic [DW-1:0] din);
    int n;
    n = 0;
    while (!insn_req && n < 20) begin @(posedge clk); #1; n++; end
    if (!insn_req) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: got insn_req 0 expected 1 within 20 cycles");
    end
    insn = w; insn_ack = 1'b1;
    @(posedge clk); #1;
    insn_ack = 1'b0; insn = '0;
    @(posedge clk); #1;
    if (data_req) begin
      repeat (wait_n) begin @(posedge clk); #1; end
      data_in = din; data_ack = 1'b1;
      @(posedge clk); #1;
      data_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   cnt;
    tbl[0] = '{a: 32'd5,          b: 32'd7,          imm: 5'h1F, op: 1'b0, exp: 32'hFFFFFFFD};
    tbl[1] = '{a: 32'hFFFFFFFF,   b: 32'd1,          imm: 5'h00, op: 1'b1, exp: 32'h00000000};
    tbl[2] = '{a: 32'h80000000,   b: 32'd1,          imm: 5'h00, op: 1'b0, exp: 32'h7FFFFFFF};
    tbl[3] = '{a: 32'h12345678,   b: 32'h11111111,   imm: 5'h0F, op: 1'b1, exp: 32'h23456798};
    tbl[4] = '{a: 32'd0,          b: 32'd0,          imm: 5'h10, op: 1'b1, exp: 32'hFFFFFFF0};
    tbl[5] = '{a: 32'd100,        b: 32'd100,        imm: 5'h03, op: 1'b0, exp: 32'h00000003};

    // Reset state
    do_reset();
    chk("rst_insn_req", 64'(insn_req), 64'd1);
    chk("rst_insn_addr", 64'(insn_addr), 64'd0);
    chk("rst_data_req", 64'(data_req), 64'd0);
    chk("rst_data_w", 64'(data_w), 64'd0);
    chk("rst_data_addr", 64'(data_addr), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_reg31", 64'(reg_31), 64'd0);

    // Back-to-back ALU op with ack held: retires in 2 cycles
    insn = enc(5'd0, 5'd0, 5'd1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    insn_ack = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    insn_ack = 1'b0;
    chk("alu_lat_instret", 64'(instret), 64'd1);
    chk("alu_lat_pc", 64'(insn_addr), 64'd1);
    chk("alu_lat_req", 64'(insn_req), 64'd1);
    sb_q.push_back('{addr: 12'd1, data: 32'd3});
    run(st(5'd1, 5'd1), 0, '0);

    // ALU vector table
    for (int i = 0; i < 6; i++) begin
      run(ld(5'd1), 0, tbl[i].a);
      run(ld(5'd2), 1, tbl[i].b);
      run(enc(5'd1, 5'd2, 5'd3, tbl[i].imm, 1'b0, 1'b1, tbl[i].op, 1'b0, 1'b0), 0, '0);
      sb_q.push_back('{addr: AW'(i + 2), data: tbl[i].exp});
      run(st(5'd3, 5'(i + 2)), i % 3, '0);
    end

    // Loads to r5 and r0; store+r_src does not write
    run(ld(5'd5), 2, 32'hAA);
    sb_q.push_back('{addr: 12'd10, data: 32'hAA});
    run(st(5'd5, 5'd10), 0, '0);
    run(ld(5'd0), 0, 32'h55);
    sb_q.push_back('{addr: 12'd11, data: 32'h0});
    run(st(5'd0, 5'd11), 0, '0);
    sb_q.push_back('{addr: 12'd12, data: 32'hAA});
    run(enc(5'd0, 5'd0, 5'd5, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0), 0, 32'h33);
    sb_q.push_back('{addr: 12'd13, data: 32'hAA});
    run(st(5'd5, 5'd13), 0, '0);

    // Store with 3-cycle ack delay; stray insn_ack and data_ack ignored
    do_reset();
    run(ld(5'd1), 0, 32'd4);
    run(ld(5'd2), 0, 32'd9);
    sb_q.push_back('{addr: 12'd4, data: 32'd9});
    insn = enc(5'd1, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    insn_ack = 1'b1;
    @(posedge clk); #1;
    insn_ack = 1'b0;
    @(posedge clk); #1;
    cnt = int'(data_req);
    chk("st_data_w", 64'(data_w), 64'd1);
    chk("st_data_addr", 64'(data_addr), 64'd4);
    insn = enc(5'd0, 5'd0, 5'd31, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    insn_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("st_wait_pc", 64'(insn_addr), 64'd2);
      chk("st_wait_instret", 64'(instret), 64'd2);
      @(posedge clk); #1;
      cnt += int'(data_req);
    end
    insn_ack = 1'b0;
    data_ack = 1'b1;
    @(posedge clk); #1;
    data_ack = 1'b0;
    chk("st_req_cycles", 64'(cnt), 64'd4);
    chk("st_req_dropped", 64'(data_req), 64'd0);
    chk("st_pc_after", 64'(insn_addr), 64'd3);
    chk("st_instret_after", 64'(instret), 64'd3);
    chk("st_stray_insn", 64'(reg_31), 64'd0);
    data_ack = 1'b1;
    @(posedge clk); #1;
    data_ack = 1'b0;
    chk("fetch_stray_dack", 64'(instret), 64'd3);

    // Branches: relative (u_dut) vs absolute (u_abs)
    do_reset();
    run(ld(5'd31), 0, 32'hFFFFFFFE);
    for (int k = 0; k < 4; k++) run(enc(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 0, '0);
    chk("br_pc_before", 64'(insn_addr), 64'd5);
    run(enc(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 0, '0);
    chk("br_rel_neg", 64'(insn_addr), 64'd3);
    chk("br_abs_neg", 64'(a_insn_addr), 64'hFFE);
    run(ld(5'd31), 0, 32'h10);
    run(enc(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 0, '0);
    chk("br_rel_pos", 64'(insn_addr), 64'h14);
    chk("br_abs_pos", 64'(a_insn_addr), 64'h10);
    run(enc(5'd0, 5'd0, 5'd31, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1), 0, 32'h100);
    chk("br_old_r31_rel", 64'(insn_addr), 64'h24);
    chk("br_old_r31_abs", 64'(a_insn_addr), 64'h10);
    chk("br_load_r31", 64'(reg_31), 64'h100);

    // Reset while in MEM with data_ack in the same cycle
    do_reset();
    run(ld(5'd31), 0, 32'h55);
    chk("rm_pre_r31", 64'(reg_31), 64'h55);
    chk("rm_pre_instret", 64'(instret), 64'd1);
    insn = ld(5'd31);
    insn_ack = 1'b1;
    @(posedge clk); #1;
    insn_ack = 1'b0;
    @(posedge clk); #1;
    chk("rm_in_mem", 64'(data_req), 64'd1);
    data_in = 32'h77; data_ack = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; data_ack = 1'b0;
    chk("rm_data_req", 64'(data_req), 64'd0);
    chk("rm_r31", 64'(reg_31), 64'd0);
    chk("rm_instret", 64'(instret), 64'd0);
    chk("rm_pc", 64'(insn_addr), 64'd0);
    chk("rm_insn_req", 64'(insn_req), 64'd1);

    repeat (2) @(posedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
